// File: rtl/fetch_pkg.sv
// Shared types and helpers for the queued instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned IALIGN     = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    // Wide enough for any XLEN up to 64; callers size-cast in and out.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'(IALIGN - 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO holding fetched {pc, instr} entries; flush beats enq/deq.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     enq_i,
    input  entry_t                   enq_data_i,
    input  logic                     deq_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output entry_t                   head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_enq;
    logic               do_deq;

    assign do_enq = enq_i && !flush_i;
    assign do_deq = deq_i && !flush_i && (cnt_q != '0);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_enq) wr_d = wr_q + PTR_W'(1);
            if (do_deq) rd_d = rd_q + PTR_W'(1);
            if (do_enq && !do_deq) cnt_d = cnt_q + CNT_W'(1);
            if (!do_enq && do_deq) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_enq) mem_q[wr_q] <= enq_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clk) disable iff (reset) !(do_enq && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_stage_q.sv
// Instruction fetch stage: PC, credit-limited imem issue, epoch squash of stale reads,
// and a fetch queue feeding Decode through a valid/ready handshake.
module fetch_stage_q
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            InstrReadyD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            InstrValidF,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            epoch_q, epoch_d;
    logic            req_epoch_q, req_epoch_d;
    logic            issue;
    logic            resp_ok;
    logic            deq;
    logic [CNT_W-1:0] count;
    entry_t          head;
    entry_t          enq_data;

    // Credits count both queued entries and the read still in flight.
    assign issue   = !reset && !PCSrcE && ((int'(count) + int'(inflight_q)) < int'(QDEPTH));
    assign resp_ok = inflight_q && (req_epoch_q == epoch_q) && !PCSrcE;
    assign deq     = InstrValidF && InstrReadyD;

    assign enq_data.pc    = req_pc_q;
    assign enq_data.instr = imem_rdata;

    always_comb begin
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        req_pc_d    = req_pc_q;
        req_epoch_d = req_epoch_q;
        inflight_d  = issue;
        if (PCSrcE) begin
            pc_d    = XLEN'(align_pc(64'(PCTargetE)));
            epoch_d = ~epoch_q;
        end else if (issue) begin
            pc_d        = pc_q + XLEN'(IALIGN);
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
        end
    end

    fetch_queue #(
        .DEPTH   (QDEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (PCSrcE),
        .enq_i      (resp_ok),
        .enq_data_i (enq_data),
        .deq_i      (deq),
        .count_o    (count),
        .head_o     (head)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    // Head outputs are forced to zero while reset is held, before the slots are cleared.
    assign InstrValidF = !reset && (count != '0);
    assign InstrF      = reset ? '0 : head.instr;
    assign PCF         = reset ? '0 : head.pc;
    assign PCPlus4F    = PCF + XLEN'(IALIGN);

endmodule

// File: tb/tb_fetch_stage_q.sv
// Directed bench for fetch_stage_q with a one-cycle synchronous-read memory model.
module tb_fetch_stage_q;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        InstrReadyD = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        InstrValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;

    int errors = 0;
    int checks = 0;

    fetch_stage_q #(.XLEN(32), .RESET_PC(32'h0000_0100), .QDEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .InstrReadyD (InstrReadyD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .InstrValidF (InstrValidF),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ KEY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCSrcE = 1'b0; InstrReadyD = 1'b1;
        tick(); tick(); #1;
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", InstrValidF); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rst_pcf: got %h want 0", PCF); end
        checks++; if (InstrF !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", InstrF); end
        checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL rst_pcplus4: got %h want 4", PCPlus4F); end
        tick(); reset = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL boot_c0: req=%b addr=%h want 1/100", imem_req, imem_addr); end
        tick(); #1;
        checks++; if (imem_addr !== 32'h104 || InstrValidF !== 1'b0) begin errors++; $display("FAIL boot_c1: addr=%h valid=%b want 104/0", imem_addr, InstrValidF); end
        tick(); #1;
        checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL boot_c2_addr: got %h want 108", imem_addr); end
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h100 || PCPlus4F !== 32'h104) begin errors++; $display("FAIL boot_c2_head: valid=%b pcf=%h pc4=%h want 1/100/104", InstrValidF, PCF, PCPlus4F); end
        checks++; if (InstrF !== (32'h100 ^ KEY)) begin errors++; $display("FAIL boot_c2_instr: got %h want %h", InstrF, 32'h100 ^ KEY); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h104) begin errors++; $display("FAIL boot_c3: valid=%b pcf=%h want 1/104", InstrValidF, PCF); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs [8];
        logic [31:0] pcs [5];
        int nreq = 0;
        int got = 0;
        PCSrcE = 1'b1; PCTargetE = 32'h0; InstrReadyD = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_redir_req: got %b want 0", imem_req); end
        tick(); PCSrcE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (imem_req) begin
                if (nreq < 8) addrs[nreq] = imem_addr;
                nreq++;
            end
            tick();
        end
        checks++; if (nreq !== 4) begin errors++; $display("FAIL bp_nreq: got %0d want 4", nreq); end
        for (int i = 0; i < 4 && i < nreq; i++) begin
            checks++; if (addrs[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_addr%0d: got %h want %h", i, addrs[i], 32'(i * 4)); end
        end
        InstrReadyD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (InstrValidF && got < 5) begin
                pcs[got] = PCF;
                got++;
            end
            tick();
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_drain_cnt: got %0d want 5", got); end
        for (int i = 0; i < got; i++) begin
            checks++; if (pcs[i] !== 32'(i * 4)) begin errors++; $display("FAIL bp_pcf%0d: got %h want %h", i, pcs[i], 32'(i * 4)); end
        end
    endtask

    task automatic test_redirect();
        PCSrcE = 1'b1; PCTargetE = 32'h1000; InstrReadyD = 1'b0;
        tick(); PCSrcE = 1'b0;
        tick(); tick(); tick(); tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h1000) begin errors++; $display("FAIL rd_prefill: valid=%b pcf=%h want 1/1000", InstrValidF, PCF); end
        PCSrcE = 1'b1; PCTargetE = 32'h203; InstrReadyD = 1'b1; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_t_req: got %b want 0", imem_req); end
        tick(); PCSrcE = 1'b0; #1;
        checks++; if (InstrValidF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rd_t1: valid=%b req=%b addr=%h want 0/1/200", InstrValidF, imem_req, imem_addr); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL rd_t2_valid: got %b want 0", InstrValidF); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h200) begin errors++; $display("FAIL rd_t3: valid=%b pcf=%h want 1/200", InstrValidF, PCF); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h204) begin errors++; $display("FAIL rd_t4: valid=%b pcf=%h want 1/204", InstrValidF, PCF); end
        tick();
    endtask

    task automatic test_back_to_back();
        InstrReadyD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h400; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_t_req: got %b want 0", imem_req); end
        tick(); PCTargetE = 32'h800; #1;
        checks++; if (imem_req !== 1'b0 || InstrValidF !== 1'b0) begin errors++; $display("FAIL b2b_t1: req=%b valid=%b want 0/0", imem_req, InstrValidF); end
        tick(); PCSrcE = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h800 || InstrValidF !== 1'b0) begin errors++; $display("FAIL b2b_t2: req=%b addr=%h valid=%b want 1/800/0", imem_req, imem_addr, InstrValidF); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b0) begin errors++; $display("FAIL b2b_t3_valid: got %b want 0", InstrValidF); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h800) begin errors++; $display("FAIL b2b_t4: valid=%b pcf=%h want 1/800", InstrValidF, PCF); end
        for (int k = 1; k <= 2; k++) begin
            tick(); #1;
            checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h800 + 32'(4 * k)) begin errors++; $display("FAIL b2b_seq%0d: valid=%b pcf=%h want 1/%h", k, InstrValidF, PCF, 32'h800 + 32'(4 * k)); end
        end
        tick();
    endtask

    task automatic test_wrap();
        InstrReadyD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        tick(); PCSrcE = 1'b0; #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); end
        tick(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tick(); #1;
        checks++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_head: pcf=%h pc4=%h want fffffffc/0", PCF, PCPlus4F); end
        checks++; if (InstrF !== (32'hFFFF_FFFC ^ KEY)) begin errors++; $display("FAIL wrap_instr: got %h want %h", InstrF, 32'hFFFF_FFFC ^ KEY); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h0) begin errors++; $display("FAIL wrap_next: valid=%b pcf=%h want 1/0", InstrValidF, PCF); end
        tick();
    endtask

    task automatic test_reset_midstream();
        InstrReadyD = 1'b1; reset = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h700; #1;
        checks++; if (imem_req !== 1'b0 || InstrValidF !== 1'b0) begin errors++; $display("FAIL mrst_s: req=%b valid=%b want 0/0", imem_req, InstrValidF); end
        tick(); PCSrcE = 1'b0; #1;
        checks++; if (imem_req !== 1'b0 || InstrValidF !== 1'b0 || PCF !== 32'h0) begin errors++; $display("FAIL mrst_s1: req=%b valid=%b pcf=%h want 0/0/0", imem_req, InstrValidF, PCF); end
        tick(); reset = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || InstrValidF !== 1'b0) begin errors++; $display("FAIL mrst_c0: req=%b addr=%h valid=%b want 1/100/0", imem_req, imem_addr, InstrValidF); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("FAIL mrst_c1: valid=%b addr=%h want 0/104", InstrValidF, imem_addr); end
        tick(); #1;
        checks++; if (InstrValidF !== 1'b1 || PCF !== 32'h100) begin errors++; $display("FAIL mrst_c2: valid=%b pcf=%h want 1/100", InstrValidF, PCF); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage_q.md
Name: fetch_stage_q

Overview:
Parametrised successor to the single-register instruction fetch stage. It holds the PC and issues one word-aligned request per cycle to a synchronous-read instruction memory. Returned words are buffered with their PCs in a small flushable queue, which decouples fetch from decode through a valid/ready handshake. The block sits between the branch-resolution logic in Execute and the Decode stage. It replaces the stall-only interface with credit-based flow control and epoch-based squash of in-flight reads.

Parameters:
XLEN, 32, width of PC and instruction word
RESET_PC, 32'h0000_0000, PC fetched first after reset; must be 4-byte aligned
QDEPTH, 4, fetch queue entries; power of 2, >= 2 (>= 3 needed for 1 instr/cycle throughput)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
PCSrcE  in  1  redirect request from Execute (taken branch/jump)
PCTargetE  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0
InstrReadyD  in  1  Decode accepts the head entry this cycle
imem_req  out  1  read request to instruction memory
imem_addr  out  XLEN  read address, valid when imem_req=1
imem_rdata  in  XLEN  read data, valid exactly 1 cycle after the accepted imem_req
InstrValidF  out  1  queue head holds a valid instruction
InstrF  out  XLEN  head instruction
PCF  out  XLEN  PC of head instruction
PCPlus4F  out  XLEN  PCF + 4, modulo 2^XLEN

Behaviour:
- Reset (reset=1 at the clock edge):
  - pc <= RESET_PC; queue count, read pointer and write pointer <= 0; inflight <= 0; epoch <= 0.
  - All queue entries <= 0.
  - While reset=1: InstrValidF=0, imem_req=0, InstrF=PCF=0, PCPlus4F=4.
  - Reset has priority over every other input, including a redirect in the same cycle.
- Issue:
  - imem_req = !reset && !PCSrcE && (count + inflight < QDEPTH).
  - The issue decision uses registered count and inflight only; there is no combinational path from InstrReadyD to imem_req.
  - imem_addr = pc. On issue: pc <= pc + 4 (wraps at 2^XLEN), inflight <= 1, and the current epoch is captured with the request.
- Response:
  - In the cycle after an issue, imem_rdata and the issued PC are enqueued, unless the captured epoch differs from the current epoch; in that case the response is dropped.
  - inflight clears at that edge unless a new request is issued in the same cycle.
- Dequeue:
  - Occurs when InstrValidF && InstrReadyD. Read pointer advances and count decrements.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - The credit check guarantees there is never an enqueue into a full queue; a simulation assertion flags any violation.
- Outputs:
  - InstrValidF = (count != 0).
  - InstrF/PCF come combinationally from the head entry; PCPlus4F = PCF + 4.
  - When the queue is empty, the outputs show the stale head slot; consumers must qualify them with InstrValidF.
- Redirect (PCSrcE=1, reset=0):
  - pc <= {PCTargetE[XLEN-1:2], 2'b00}; queue flushed (count and pointers <= 0); epoch toggles.
  - imem_req=0 in the redirect cycle.
  - A dequeue in the same cycle is ignored, since the flush wins.
  - A response arriving in the same cycle is discarded.
  - A response arriving the next cycle carries the old epoch and is dropped.
- Latency:
  - Reset deasserted before edge 0: request at cycle 0, enqueue at edge 1, InstrValidF=1 in cycle 2.
  - Redirect at cycle t: target requested at t+1, InstrValidF with PCF=target at t+3.
- Throughput: one instruction per cycle sustained with InstrReadyD=1 and QDEPTH >= 3.
- Back-pressure:
  - With InstrReadyD=0, the queue fills to exactly QDEPTH entries, counting the last in-flight read; issue then stops.
  - No instruction is lost or duplicated.
  - Issue resumes the cycle after the first dequeue.
- Back-to-back redirects on consecutive cycles: the last one wins; earlier targets are never enqueued.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc, instr}
  - IALIGN=4
  - NOP_INSTR=32'h0000_0013
  - helper function align_pc()
- Sub-module fetch_queue (parametrised on QDEPTH and entry type):
  - synchronous FIFO with enq/deq/flush, count output, head output
  - flush has priority over enq/deq
- The top level holds the pc, inflight and epoch registers, the credit logic and the response-squash logic.

Test Plan:
- Reset release, RESET_PC=0x100, InstrReadyD=1 -> imem_addr 0x100,0x104,0x108 on consecutive cycles; InstrValidF first high at cycle 2 with PCF=0x100, PCPlus4F=0x104.
- InstrReadyD=0 for 10 cycles, QDEPTH=4 -> exactly 4 requests (0x0..0xC), then imem_req=0; on release, PCF sequence is 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
- PCSrcE=1, PCTargetE=0x203 at cycle t while queue holds 3 entries -> InstrValidF=0 at t+1 and t+2, PCF=0x200 at t+3, no old-path PC ever presented.
- PCSrcE pulses at t (target 0x400) and t+1 (target 0x800) -> 0x400 never enqueued; first valid PCF=0x800 at t+4.
- pc=0xFFFF_FFFC fetch -> next imem_addr=0x0; PCPlus4F=0x0 when PCF=0xFFFF_FFFC.
- reset asserted mid-stream with PCSrcE=1 in the same cycle -> next cycle InstrValidF=0, imem_req=0; after release, first request is RESET_PC; the stale in-flight response is not enqueued.
